// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect mixer: register map, control/status
// bit positions and the frame sequencer states.
package sfx_pkg;

    localparam logic [1:0] REG_START  = 2'd0;
    localparam logic [1:0] REG_END    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_GO        = 0;
    localparam int CTRL_LOOP      = 1;
    localparam int CTRL_ATTEN_LSB = 2;
    localparam int CTRL_STOP      = 5;

    localparam int STAT_ACTIVE  = 0;
    localparam int STAT_OVERRUN = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_OUT
    } state_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sfx_mixer_player_if.sv
// Bundle of the mixer's bus-side signals: Avalon-MM register slave, sample ROM
// read port, audio sample tick and the mixed-sample valid/ready stream.
interface sfx_mixer_player_if
    import sfx_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16,
    parameter int ROM_AW   = 14
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [CH_W+1:0]     address;
    logic                chipselect;
    logic                write;
    logic                read;
    logic [15:0]         writedata;
    logic [15:0]         readdata;

    logic                sample_tick;

    logic [ROM_AW-1:0]   rom_address;
    logic [SAMPLE_W-1:0] rom_readdata;

    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;

    // The mixer itself.
    modport slave (
        input  address, chipselect, write, read, writedata,
        output readdata,
        input  sample_tick,
        output rom_address,
        input  rom_readdata,
        output out_valid, out_data,
        input  out_ready
    );

    // Software, ROM and codec side.
    modport master (
        output address, chipselect, write, read, writedata,
        input  readdata,
        output sample_tick,
        input  rom_address,
        output rom_readdata,
        input  out_valid, out_data,
        output out_ready
    );

endinterface

// File: rtl/sfx_channel.sv
// One playback channel: START/END/CTRL registers, play pointer and active flag.
// The pointer steps once per frame on i_advance; register writes take priority.
module sfx_channel
    import sfx_pkg::*;
#(
    parameter int ROM_AW = 14
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [1:0]        i_wr_reg,
    input  logic [15:0]       i_wr_data,
    input  logic              i_advance,
    output logic [ROM_AW-1:0] o_ptr,
    output logic [ROM_AW-1:0] o_start,
    output logic [ROM_AW-1:0] o_end,
    output logic              o_active,
    output logic              o_loop,
    output logic [2:0]        o_atten
);

    logic [ROM_AW-1:0] r_start;
    logic [ROM_AW-1:0] r_end;
    logic [ROM_AW-1:0] r_ptr;
    logic              r_active;
    logic              r_loop;
    logic [2:0]        r_atten;

    logic w_unused;
    assign w_unused = ^i_wr_data;

    // NOTE: state is updated with non-blocking assignments only; the register
    // write below deliberately comes after the advance so that it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start  <= '0;
            r_end    <= '0;
            r_ptr    <= '0;
            r_active <= 1'b0;
            r_loop   <= 1'b0;
            r_atten  <= '0;
        end else begin
            if (i_advance && r_active) begin
                if (r_ptr == r_end) begin
                    if (r_loop) r_ptr    <= r_start;
                    else        r_active <= 1'b0;
                end else begin
                    r_ptr <= r_ptr + ROM_AW'(1);
                end
            end
            if (i_wr_en) begin
                case (i_wr_reg)
                    REG_START: r_start <= i_wr_data[ROM_AW-1:0];
                    REG_END:   r_end   <= i_wr_data[ROM_AW-1:0];
                    REG_CTRL: begin
                        r_loop  <= i_wr_data[CTRL_LOOP];
                        r_atten <= i_wr_data[CTRL_ATTEN_LSB +: 3];
                        if (i_wr_data[CTRL_GO]) begin
                            r_ptr    <= r_start;
                            r_active <= 1'b1;
                        end
                        if (i_wr_data[CTRL_STOP]) r_active <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ptr    = r_ptr;
    assign o_start  = r_start;
    assign o_end    = r_end;
    assign o_active = r_active;
    assign o_loop   = r_loop;
    assign o_atten  = r_atten;

endmodule

// File: rtl/sfx_mixer_player.sv
// Multi-channel sample player: on each tick every channel is fetched from the
// shared ROM, attenuated, summed with saturation and offered downstream.
module sfx_mixer_player
    import sfx_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16,
    parameter int ROM_AW   = 14
)
(
    input logic               clk,
    input logic               reset,
    sfx_mixer_player_if.slave bus
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int ACC_W = SAMPLE_W + CH_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(CH_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(CH_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CH_W-1:0]         r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_d_vld;
    logic [2:0]              r_d_atten;
    logic [SAMPLE_W-1:0]     r_out_data;
    logic                    r_overrun;
    logic [15:0]             r_readdata;

    logic                    w_wr;
    logic                    w_rd;
    logic [CH_W-1:0]         w_sel_ch;
    logic [1:0]              w_sel_reg;

    logic [NUM_CH-1:0][ROM_AW-1:0] w_ptr;
    logic [NUM_CH-1:0][ROM_AW-1:0] w_start;
    logic [NUM_CH-1:0][ROM_AW-1:0] w_end;
    logic [NUM_CH-1:0][2:0]        w_atten;
    logic [NUM_CH-1:0]             w_active;
    logic [NUM_CH-1:0]             w_loop;

    logic [ROM_AW-1:0]       w_fetch_ptr;
    logic                    w_fetch_act;
    logic [2:0]              w_fetch_atten;
    logic [15:0]             w_rd_val;

    logic signed [SAMPLE_W-1:0] w_rom_s;
    logic signed [SAMPLE_W-1:0] w_shifted;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic [SAMPLE_W-1:0]        w_sat;

    assign w_wr      = bus.chipselect & bus.write;
    assign w_rd      = bus.chipselect & bus.read;
    assign w_sel_ch  = bus.address[CH_W+1:2];
    assign w_sel_reg = bus.address[1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sfx_channel #(.ROM_AW(ROM_AW)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (w_wr && (w_sel_ch == CH_W'(g))),
            .i_wr_reg  (w_sel_reg),
            .i_wr_data (bus.writedata),
            .i_advance ((r_state == ST_FETCH) && (r_idx == CH_W'(g))),
            .o_ptr     (w_ptr[g]),
            .o_start   (w_start[g]),
            .o_end     (w_end[g]),
            .o_active  (w_active[g]),
            .o_loop    (w_loop[g]),
            .o_atten   (w_atten[g])
        );
    end

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_fetch_ptr   = '0;
        w_fetch_act   = 1'b0;
        w_fetch_atten = '0;
        w_rd_val      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_idx == CH_W'(k)) begin
                w_fetch_ptr   = w_ptr[k];
                w_fetch_act   = w_active[k];
                w_fetch_atten = w_atten[k];
            end
            if (w_sel_ch == CH_W'(k)) begin
                case (w_sel_reg)
                    REG_START: w_rd_val = 16'(w_start[k]);
                    REG_END:   w_rd_val = 16'(w_end[k]);
                    REG_CTRL: begin
                        w_rd_val[CTRL_LOOP]            = w_loop[k];
                        w_rd_val[CTRL_ATTEN_LSB +: 3]  = w_atten[k];
                    end
                    default: begin
                        w_rd_val[STAT_ACTIVE]  = w_active[k];
                        w_rd_val[STAT_OVERRUN] = r_overrun;
                    end
                endcase
            end
        end
    end

    // ROM data lags the address by one cycle, so the term uses the delayed
    // active flag and attenuation captured when the address was issued.
    assign w_rom_s    = bus.rom_readdata;
    assign w_shifted  = w_rom_s >>> r_d_atten;
    assign w_term     = r_d_vld ? {{CH_W{w_shifted[SAMPLE_W-1]}}, w_shifted} : '0;
    assign w_acc_next = r_acc + w_term;

    always_comb begin
        w_sat = w_acc_next[SAMPLE_W-1:0];
        if (w_acc_next > SAT_MAX)      w_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (w_acc_next < SAT_MIN) w_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.sample_tick) w_state_next = ST_FETCH;
            ST_FETCH: if (r_idx == CH_W'(NUM_CH - 1)) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_OUT;
            ST_OUT:   if (bus.out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_acc      <= '0;
            r_d_vld    <= 1'b0;
            r_d_atten  <= '0;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_d_vld   <= (r_state == ST_FETCH) && w_fetch_act;
            r_d_atten <= w_fetch_atten;
            case (r_state)
                ST_IDLE: if (bus.sample_tick) begin
                    r_acc <= '0;
                    r_idx <= '0;
                end
                ST_FETCH: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + CH_W'(1);
                end
                ST_DRAIN: r_out_data <= w_sat;
                default: ;
            endcase
            // A new overrun event outranks a simultaneous software clear.
            if (bus.sample_tick && (r_state != ST_IDLE))
                r_overrun <= 1'b1;
            else if (w_wr && (w_sel_reg == REG_STATUS) && bus.writedata[STAT_OVERRUN])
                r_overrun <= 1'b0;
            if (w_rd) r_readdata <= w_rd_val;
        end
    end

    assign bus.rom_address = ((r_state == ST_FETCH) && w_fetch_act) ? w_fetch_ptr : '0;
    assign bus.out_valid   = (r_state == ST_OUT);
    assign bus.out_data    = r_out_data;
    assign bus.readdata    = r_readdata;

endmodule

// File: tb/tb_sfx_mixer_player.sv
// Self-checking bench for sfx_mixer_player: directed sequences, a vector table
// and randomized playback compared with a per-frame behavioural model.
module tb_sfx_mixer_player;
    import sfx_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int ROM_AW   = 14;
    localparam int ROM_N    = 1 << ROM_AW;

    typedef struct {
        int st;
        int en;
        int ptr;
        bit lp;
        bit act;
        int atten;
    } mch_t;

    typedef struct {
        int ch;
        int addr;
        int val;
        int atten;
        int exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [SAMPLE_W-1:0] rom [ROM_N];
    logic [ROM_AW-1:0]   fetch_addr [NUM_CH];
    mch_t                m [NUM_CH];

    sfx_mixer_player_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ROM_AW(ROM_AW)) bus ();

    sfx_mixer_player #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ROM_AW(ROM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_readdata <= rom[bus.rom_address];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m[k] = '{default: 0};
    endtask

    // One sample: sum every active channel's attenuated word, then step it.
    function automatic int model_frame();
        int sum = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k].act) begin
                sum += int'($signed(rom[m[k].ptr]) >>> m[k].atten);
                if (m[k].ptr == m[k].en) begin
                    if (m[k].lp) m[k].ptr = m[k].st;
                    else         m[k].act = 1'b0;
                end else begin
                    m[k].ptr = (m[k].ptr + 1) % ROM_N;
                end
            end
        end
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum;
    endfunction

    task automatic reg_write(input int ch, input int rg, input int d);
        logic [15:0] dv;
        dv = 16'(d);
        @(negedge clk);
        bus.address    = 4'(ch * 4 + rg);
        bus.writedata  = dv;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        case (rg)
            0: m[ch].st = int'(dv[13:0]);
            1: m[ch].en = int'(dv[13:0]);
            2: begin
                m[ch].lp    = dv[1];
                m[ch].atten = int'(dv[4:2]);
                if (dv[0]) begin
                    m[ch].ptr = m[ch].st;
                    m[ch].act = 1'b1;
                end
                if (dv[5]) m[ch].act = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic reg_read(input int ch, input int rg, output int d);
        @(negedge clk);
        bus.address    = 4'(ch * 4 + rg);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        @(posedge clk);
        #1;
        d = int'(bus.readdata);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic start_wait(output int got);
        int cyc = 0;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        while (!bus.out_valid && cyc < 40) begin
            if (cyc < NUM_CH) fetch_addr[cyc] = bus.rom_address;
            @(negedge clk);
            cyc++;
        end
        check("out_valid_rise", int'(bus.out_valid), 1);
        check("tick_to_valid_latency", cyc, NUM_CH + 1);
        got = int'($signed(bus.out_data));
    endtask

    task automatic accept(input int delay);
        repeat (delay) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", int'(bus.out_valid), 0);
    endtask

    task automatic run_frame(output int got);
        start_wait(got);
        accept(0);
    endtask

    initial begin
        int   got, d, cnt;
        int   seq_exp [4];
        vec_t vecs [6];

        bus.address     = '0;
        bus.chipselect  = 1'b0;
        bus.write       = 1'b0;
        bus.read        = 1'b0;
        bus.writedata   = '0;
        bus.sample_tick = 1'b0;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < ROM_N; i++) rom[i] = 16'($urandom);
        model_reset();

        seq_exp[0] = 100; seq_exp[1] = 200; seq_exp[2] = 300; seq_exp[3] = 0;
        vecs[0] = '{2, 40, -4,     2, -1};
        vecs[1] = '{2, 41, 400,    2, 100};
        vecs[2] = '{0, 42, 32767,  0, 32767};
        vecs[3] = '{1, 43, -32768, 7, -256};
        vecs[4] = '{3, 44, -1,     7, -1};
        vecs[5] = '{3, 45, 1,      1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_rom_address", int'(bus.rom_address), 0);
        check("rst_readdata", int'(bus.readdata), 0);
        reset = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            reg_read(k, 3, d);
            check($sformatf("rst_status_ch%0d", k), d, 0);
        end
        reg_read(1, 0, d); check("rst_start_ch1", d, 0);
        reg_read(3, 1, d); check("rst_end_ch3", d, 0);
        reg_read(2, 2, d); check("rst_ctrl_ch2", d, 0);

        // One-shot region on channel 0
        rom[10] = 16'd100; rom[11] = 16'd200; rom[12] = 16'd300;
        reg_write(0, 0, 10);
        reg_write(0, 1, 12);
        reg_write(0, 2, 1);
        reg_read(0, 0, d); check("start_readback", d, 10);
        for (int f = 0; f < 4; f++) begin
            run_frame(got);
            void'(model_frame());
            check($sformatf("oneshot_f%0d", f), got, seq_exp[f]);
            if (f == 0) check("oneshot_rom_addr_ch0", int'(fetch_addr[0]), 10);
            if (f == 1) begin reg_read(0, 3, d); check("oneshot_active_mid", d, 1); end
            if (f == 2) begin reg_read(0, 3, d); check("oneshot_active_end", d, 0); end
        end

        // Single-word loop on channel 1, then STOP
        rom[5] = 16'hFFF9;
        reg_write(1, 0, 5);
        reg_write(1, 1, 5);
        reg_write(1, 2, 3);
        reg_read(1, 2, d); check("loop_ctrl_readback", d, 2);
        for (int f = 0; f < 3; f++) begin
            run_frame(got);
            void'(model_frame());
            check($sformatf("loop_f%0d", f), got, -7);
        end
        check("loop_rom_addr_ch0_idle", int'(fetch_addr[0]), 0);
        check("loop_rom_addr_ch1", int'(fetch_addr[1]), 5);
        reg_read(1, 3, d); check("loop_active", d, 1);
        reg_write(1, 2, 32 | 2);
        reg_read(1, 2, d); check("stop_ctrl_readback", d, 2);
        run_frame(got);
        void'(model_frame());
        check("after_stop", got, 0);

        // Saturation, both rails
        rom[20] = 16'h7000;
        for (int k = 0; k < NUM_CH; k++) begin
            reg_write(k, 0, 20); reg_write(k, 1, 20); reg_write(k, 2, 1);
        end
        run_frame(got); void'(model_frame());
        check("sat_pos", got, 32767);
        rom[20] = 16'h9000;
        for (int k = 0; k < NUM_CH; k++) reg_write(k, 2, 1);
        run_frame(got); void'(model_frame());
        check("sat_neg", got, -32768);

        // Vector table: single-word, single-channel playback with attenuation
        for (int i = 0; i < 6; i++) begin
            rom[vecs[i].addr] = 16'(vecs[i].val);
            reg_write(vecs[i].ch, 0, vecs[i].addr);
            reg_write(vecs[i].ch, 1, vecs[i].addr);
            reg_write(vecs[i].ch, 2, 1 | (vecs[i].atten << 2));
            reg_read(vecs[i].ch, 2, d);
            check($sformatf("vec%0d_ctrl", i), d, vecs[i].atten << 2);
            run_frame(got);
            void'(model_frame());
            check($sformatf("vec%0d_out", i), got, vecs[i].exp);
        end

        // Overrun while output is stalled
        rom[30] = 16'd1234;
        reg_write(3, 0, 30); reg_write(3, 1, 30); reg_write(3, 2, 3);
        start_wait(got);
        void'(model_frame());
        check("ovr_first", got, 1234);
        @(negedge clk); bus.sample_tick = 1'b1;
        @(negedge clk); bus.sample_tick = 1'b0;
        reg_read(3, 3, d); check("ovr_status_set", d, 3);
        check("ovr_valid_held", int'(bus.out_valid), 1);
        check("ovr_data_held", int'($signed(bus.out_data)), 1234);
        accept(2);
        reg_write(0, 3, 2);
        reg_read(3, 3, d); check("ovr_cleared", d, 1);

        // Tick coinciding with the handshake is dropped as an overrun
        start_wait(got);
        void'(model_frame());
        check("hs_frame", got, 1234);
        bus.out_ready = 1'b1; bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.sample_tick = 1'b0;
        check("hs_valid_drop", int'(bus.out_valid), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rom_address != '0 || bus.out_valid) cnt++;
            @(negedge clk);
        end
        check("hs_no_frame_started", cnt, 0);
        reg_read(3, 3, d); check("hs_overrun", d, 3);
        reg_write(3, 3, 2);
        reg_read(3, 3, d); check("hs_overrun_cleared", d, 1);

        // Reset in the middle of a fetch
        @(negedge clk); bus.sample_tick = 1'b1;
        @(negedge clk); bus.sample_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_data", int'(bus.out_data), 0);
        check("midrst_rom_address", int'(bus.rom_address), 0);
        check("midrst_readdata", int'(bus.readdata), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("midrst_no_emit", cnt, 0);
        for (int k = 0; k < NUM_CH; k++) begin
            reg_read(k, 3, d);
            check($sformatf("midrst_status_ch%0d", k), d, 0);
        end
        run_frame(got); void'(model_frame());
        check("midrst_silent_frame", got, 0);

        // Randomized playback against the model (channel 0 wraps the ROM end)
        for (int k = 0; k < NUM_CH; k++) begin
            int st, en;
            if (k == 0) begin
                st = ROM_N - 2; en = 1;
            end else begin
                st = int'($urandom_range(0, 60));
                en = st + int'($urandom_range(0, 6));
            end
            reg_write(k, 0, st);
            reg_write(k, 1, en);
            reg_write(k, 2, 1 | (int'($urandom_range(0, 1)) << 1) | (int'($urandom_range(0, 7)) << 2));
        end
        for (int f = 0; f < 40; f++) begin
            int exp;
            if ($urandom_range(0, 3) == 0) begin
                int ch, op;
                ch = int'($urandom_range(0, NUM_CH - 1));
                op = int'($urandom_range(0, 2));
                if (op == 0)
                    reg_write(ch, 2, 1 | (int'($urandom_range(0, 1)) << 1) | (int'($urandom_range(0, 7)) << 2));
                else if (op == 1)
                    reg_write(ch, 2, 32);
                else
                    reg_write(ch, 1, int'($urandom_range(0, 70)));
            end
            start_wait(got);
            exp = model_frame();
            check($sformatf("rand_f%0d", f), got, exp);
            accept(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
